// File: rtl/debug_pkg.sv
// Shared state encoding and dcsr.cause constants for the Aquila debug halt controller.
package debug_pkg;

   localparam int CAUSE_W = 3;

   typedef enum logic [2:0] {
      ST_RUNNING    = 3'd0,
      ST_WAIT_STALL = 3'd1,
      ST_ENTERING   = 3'd2,
      ST_HALTED     = 3'd3,
      ST_RESUMING   = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CAUSE_NONE      = 3'd0,
      CAUSE_EBREAK    = 3'd1,
      CAUSE_TRIGGER   = 3'd2,
      CAUSE_HALTREQ   = 3'd3,
      CAUSE_STEP      = 3'd4,
      CAUSE_RESETHALT = 3'd5
   } cause_e;

endpackage

// File: rtl/debug_cause_arbiter.sv
// Combinational priority arbiter over debug-entry sources; also selects the
// lowest-index qualified trigger channel as a one-hot vector.
module debug_cause_arbiter #(
   parameter int NUM_TRIG = 4,
   parameter int CAUSE_W  = 3
) (
   input  logic [NUM_TRIG-1:0] trig_vec,
   input  logic                trig_mask,
   input  logic                ebreak,
   input  logic                resethalt,
   input  logic                haltreq,
   input  logic                step,
   output logic                req,
   output logic [CAUSE_W-1:0]  cause,
   output logic [NUM_TRIG-1:0] trig_hit
);
   import debug_pkg::*;

   logic [NUM_TRIG-1:0] lowest;
   logic                trig_fire;

   // Two's-complement trick isolates the lowest set bit.
   assign lowest    = trig_vec & (~trig_vec + NUM_TRIG'(1));
   assign trig_fire = (|trig_vec) && !trig_mask;

   // NOTE: every output gets a default before the priority chain so no latch is inferred.
   always_comb begin
      req      = 1'b1;
      cause    = CAUSE_W'(CAUSE_NONE);
      trig_hit = '0;
      if (trig_fire) begin
         cause    = CAUSE_W'(CAUSE_TRIGGER);
         trig_hit = lowest;
      end else if (ebreak) begin
         cause = CAUSE_W'(CAUSE_EBREAK);
      end else if (resethalt) begin
         cause = CAUSE_W'(CAUSE_RESETHALT);
      end else if (haltreq) begin
         cause = CAUSE_W'(CAUSE_HALTREQ);
      end else if (step) begin
         cause = CAUSE_W'(CAUSE_STEP);
      end else begin
         req = 1'b0;
      end
   end

endmodule

// File: rtl/debug_halt_controller.sv
// Debug entry/exit sequencer: arbitrates halt sources, masks triggers after
// flushes, issues the halt pulse to the PC unit and runs the dret handshake.
module debug_halt_controller #(
   parameter int NUM_TRIG   = 4,
   parameter int FLUSH_MASK = 2,
   parameter int CAUSE_W    = debug_pkg::CAUSE_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic                retire_i,
   input  logic                haltreq_i,
   input  logic                resethaltreq_i,
   input  logic                ebreak_i,
   input  logic                single_step_i,
   input  logic [NUM_TRIG-1:0] trig_match_i,
   input  logic [NUM_TRIG-1:0] trig_en_i,
   input  logic                dret_i,
   input  logic                halted_i,
   output logic                halt_req_o,
   output logic                save_dpc_o,
   output logic [CAUSE_W-1:0]  cause_o,
   output logic [NUM_TRIG-1:0] trig_hit_o,
   output logic                debugging_o,
   output logic                resume_ack_o
);
   import debug_pkg::*;

   // The flush cycle itself is masked, so the counter only has to cover the
   // remaining FLUSH_MASK-1 cycles.
   localparam int               CNT_W    = (FLUSH_MASK > 1) ? $clog2(FLUSH_MASK) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (FLUSH_MASK > 1) ? CNT_W'(FLUSH_MASK - 1) : '0;
   localparam logic             MASK_ON  = (FLUSH_MASK > 0);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    flush_cnt_q;
   logic                step_armed_q;
   logic                first_cycle_q;

   logic                trig_mask;
   logic                arb_req;
   logic [CAUSE_W-1:0]  arb_cause;
   logic [NUM_TRIG-1:0] arb_hit;
   logic                enter;
   logic                latch_cause;
   logic                arm_clear;
   logic                resume;

   assign trig_mask = (flush_i && MASK_ON) || (flush_cnt_q != '0);

   debug_cause_arbiter #(
      .NUM_TRIG (NUM_TRIG),
      .CAUSE_W  (CAUSE_W)
   ) u_arbiter (
      .trig_vec  (trig_match_i & trig_en_i),
      .trig_mask (trig_mask),
      .ebreak    (ebreak_i),
      .resethalt (resethaltreq_i && first_cycle_q),
      .haltreq   (haltreq_i),
      .step      (step_armed_q && retire_i),
      .req       (arb_req),
      .cause     (arb_cause),
      .trig_hit  (arb_hit)
   );

   always_comb begin
      state_d     = state_q;
      enter       = 1'b0;
      latch_cause = 1'b0;
      arm_clear   = 1'b0;
      resume      = 1'b0;
      case (state_q)
         ST_RUNNING: if (arb_req) begin
            latch_cause = 1'b1;
            arm_clear   = 1'b1;
            if (stall_i) begin
               state_d = ST_WAIT_STALL;
            end else begin
               state_d = ST_ENTERING;
               enter   = 1'b1;
            end
         end
         ST_WAIT_STALL: if (!stall_i) begin
            state_d = ST_ENTERING;
            enter   = 1'b1;
         end
         ST_ENTERING: if (halted_i) state_d = ST_HALTED;
         ST_HALTED: begin
            if (dret_i) begin
               state_d = ST_RESUMING;
            end else if (ebreak_i) begin
               // Debug-ROM re-entry keeps the original cause.
               state_d   = ST_ENTERING;
               enter     = 1'b1;
               arm_clear = 1'b1;
            end
         end
         ST_RESUMING: if (!halted_i) begin
            state_d = ST_RUNNING;
            resume  = 1'b1;
         end
         default: state_d = ST_RUNNING;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_RUNNING;
         flush_cnt_q   <= '0;
         step_armed_q  <= 1'b0;
         first_cycle_q <= 1'b1;
         halt_req_o    <= 1'b0;
         resume_ack_o  <= 1'b0;
         debugging_o   <= 1'b0;
         cause_o       <= '0;
         trig_hit_o    <= '0;
      end else begin
         state_q       <= state_d;
         first_cycle_q <= 1'b0;
         halt_req_o    <= enter;
         resume_ack_o  <= resume;

         if (flush_i) flush_cnt_q <= CNT_LOAD;
         else if (flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - CNT_W'(1);

         if (latch_cause) begin
            cause_o    <= arb_cause;
            trig_hit_o <= arb_hit;
         end

         if (arm_clear) step_armed_q <= 1'b0;
         else if (resume && single_step_i) step_armed_q <= 1'b1;

         if (state_q == ST_HALTED) debugging_o <= 1'b1;
         else if (state_q == ST_RUNNING) debugging_o <= 1'b0;
      end
   end

   assign save_dpc_o = halt_req_o && !halted_i;

endmodule

// File: doc/debug_halt_controller.md
Name: debug_halt_controller

Overview:
- Parametrised debug-entry/exit sequencer for the Aquila core, between Debug Module, CSR file (dcsr/dpc/tdata), program counter unit and execute stage.
- Arbitrates NUM_TRIG trigger channels, haltreq, resethaltreq, ebreak and single-step into one registered halt request with a latched dcsr cause.
- Masks triggers for a configurable window after pipeline flushes.
- Runs an explicit resume handshake on dret.

Parameters:
NUM_TRIG, 4, trigger channels (1..16)
FLUSH_MASK, 2, cycles trigger matches are ignored after flush_i (0 = no masking)
CAUSE_W, 3, dcsr.cause width

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset; asynchronous, active-high
stall_i  in  1  pipeline stall
flush_i  in  1  pipeline flush (branch/exception)
retire_i  in  1  instruction retired this cycle
haltreq_i  in  1  level halt request from DM
resethaltreq_i  in  1  halt-on-reset request; sampled only first cycle after reset
ebreak_i  in  1  ebreak in execute with dcsr.ebreakm=1
single_step_i  in  1  dcsr.step
trig_match_i  in  NUM_TRIG  per-channel match
trig_en_i  in  NUM_TRIG  per-channel action=enter-debug
dret_i  in  1  dret executed
halted_i  in  1  core executing from debug ROM
halt_req_o  out  1  1-cycle pulse to PC unit
save_dpc_o  out  1  write dpc this cycle
cause_o  out  CAUSE_W  latched dcsr.cause
trig_hit_o  out  NUM_TRIG  one-hot lowest-index trigger that caused entry
debugging_o  out  1  in debug mode
resume_ack_o  out  1  1-cycle pulse on completed resume

Behaviour:
- Reset values: all outputs 0; state RUNNING; flush counter 0; step_armed 0; first_cycle 1.
- Causes: EBREAK=1, TRIGGER=2, HALTREQ=3, STEP=4, RESETHALT=5.
- Qualified trigger trig_q = |(trig_match_i & trig_en_i) && flush_cnt==0.
- Priority: trigger > ebreak > resethaltreq (first_cycle only) > haltreq > step.
- Flush counter: loads FLUSH_MASK on flush_i; otherwise decrements to 0, saturating. Flush and match in the same cycle: match masked.
- Step: step_armed is set on RESUMING->RUNNING when single_step_i=1. Step request = step_armed && retire_i. step_armed clears on any debug entry.
- States:
  - RUNNING: any request -> WAIT_STALL if stall_i, else ENTERING. Cause and trig_hit are latched in the same cycle.
  - WAIT_STALL: hold; on ~stall_i -> ENTERING. Requests arriving meanwhile do not change the latched cause.
  - ENTERING: halt_req_o pulses on the entry cycle only. halted_i -> HALTED.
  - HALTED: dret_i -> RESUMING. ebreak_i -> ENTERING (debug-ROM re-entry). Re-entry pulses halt_req_o, does not write save_dpc_o, and leaves cause unchanged. dret and ebreak together: dret wins.
  - RESUMING: ~halted_i -> RUNNING, with resume_ack_o pulsed on that transition.
- save_dpc_o = halt_req_o && ~halted_i.
- debugging_o: set on the cycle after HALTED is entered; cleared on the cycle after RUNNING is re-entered. It is registered.
- trig_hit_o holds the masked one-hot of the lowest set bit of trig_match_i & trig_en_i for trigger entries. It is 0 for other causes and is held until the next entry from RUNNING.
- haltreq_i held high in RUNNING after resume: re-enters immediately (DM's responsibility to drop).
- Reset mid-operation: asynchronous return to RUNNING; all outputs 0 without waiting for a clock edge.

Decomposition:
- Package debug_pkg: state encoding, cause constants, CAUSE_W.
- Sub-module debug_cause_arbiter (combinational priority plus lowest-index one-hot, parametrised by NUM_TRIG). The FSM, flush counter and step logic stay in the top.

Test Plan:
1. Idle, no stall, trig_match_i=4'b0110, trig_en_i=4'b0100 -> halt_req_o and save_dpc_o pulse next edge; cause_o=2, trig_hit_o=4'b0100; halted_i after 3 cycles -> debugging_o=1.
2. flush_i at cycle 10 with FLUSH_MASK=2, matches at 10-12 -> no entry for 10-11; entry accepted for the match at cycle 12.
3. haltreq_i with stall_i high 5 cycles, ebreak_i in cycle 2 -> halt_req_o exactly once, when stall drops; cause_o=3.
4. Halted, dret_i with single_step_i=1; halted_i drops 2 cycles later -> resume_ack_o pulses once; on first retire_i, halt_req_o pulses with cause_o=4.
5. Halted, ebreak_i -> halt_req_o pulse, save_dpc_o=0, cause_o unchanged, debugging_o stays 1.
6. Reset released with resethaltreq_i=1 -> cause_o=5 and entry. Async rst_i asserted mid-ENTERING -> all outputs 0 before the next edge.
